reward_pickup_controller: RTL
=============================

# reward_pickup_controller

Consumer side of the reward spawn handshake. It accepts a spawn request from the reward random generator and latches the reward's type and grid position, then shows the reward on the map. When the player tank reaches the reward's cell, it collects it, answers the generator with `set_finish` and drives the resulting power-up effects. It sits between the reward generator, the tank position logic and the map/VGA renderer.

## Interface
- `EFFECT_TICKS`, 40: duration of timed effects in `tick` pulses (8-bit, 1..255).
- `BLINK_AFTER`, 32: `tick` count in SHOWN after which the marker blinks (only used with `REWARD_BLINK_EN`).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-`clk`-wide pulse at 4 Hz, synchronous to `clk`.
- `set_require` in 1: generator requests a reward on the map.
- `reward_type` in 3: 1 = extra life, 2 = speed, 3 = shield, 4 = freeze enemies; 0 = not yet valid.
- `random_xpos` in 5: reward column.
- `random_ypos` in 5: reward row.
- `tank_xpos` in 5: player tank column.
- `tank_ypos` in 5: player tank row.
- `set_finish` out 1: reward collected; high until `set_require` falls.
- `reward_valid` out 1: a reward is latched and on the map.
- `reward_show` out 1: renderer draw enable for the reward marker.
- `reward_xpos` out 5: latched reward column.
- `reward_ypos` out 5: latched reward row.
- `reward_kind` out 3: latched reward type.
- `life_add` out 1: one-cycle pulse on extra-life pickup.
- `speed_on` out 1: speed effect active.
- `shield_on` out 1: shield effect active.
- `freeze_on` out 1: freeze effect active.

## Operation
- FSM states: IDLE, SHOWN, ACK.
- **IDLE**
  - `reward_valid` = 0.
  - When `set_require`=1 and `reward_type`≠0, latch `random_xpos`, `random_ypos` and `reward_type` into `reward_xpos`, `reward_ypos` and `reward_kind`.
  - Go to SHOWN and clear the shown counter.
- **SHOWN**
  - `reward_valid` = 1.
  - If `set_require`=0: the reward expired. Go to IDLE, clear `reward_kind`, apply no effect.
  - Else if (`tank_xpos`,`tank_ypos`) == (`reward_xpos`,`reward_ypos`): the reward is collected. Apply the effect for `reward_kind` and go to ACK.
  - Expiry has priority over collection in the same cycle.
- **ACK**
  - `set_finish` = 1 and `reward_valid` = 0.
  - When `set_require`=0, drop `set_finish` and go to IDLE.
  - The handshake is full four-phase, because the generator samples `set_finish` only on its own 4 Hz edge.
- **Effects on pickup**
  - Type 1: pulse `life_add`.
  - Types 2, 3, 4: load that effect's 8-bit counter with `EFFECT_TICKS`. The matching `*_on` output is high while the counter is nonzero.
  - Each `tick` decrements every nonzero effect counter; counters saturate at 0.
  - Collecting a type whose effect is already running reloads its counter to `EFFECT_TICKS`; it does not add to the remaining count.
  - Effect counters run independently of FSM state.
- Type values 5–7 are accepted and shown but give no effect on pickup.
- The shown counter (8-bit, saturating) increments on `tick` while in SHOWN.

## Timing
- Reset values:
  - FSM = IDLE.
  - All outputs 0, including `reward_xpos`, `reward_ypos`, `reward_kind`, `set_finish` and `life_add`.
  - All effect counters 0.
- Reset may be asserted mid-effect or mid-handshake; the block returns to IDLE immediately.
- Latch latency: the latched outputs and `reward_valid` go high 1 `clk` after the qualifying IDLE sample.
- Pickup latency:
  - Position match sampled at edge N gives `set_finish`=1, `life_add` pulse and `*_on`=1 at edge N+1.
  - `reward_valid`=0 from N+1.
- `set_finish` falls 1 `clk` after `set_require` is sampled low.
- `tick` and pickup in the same cycle: the load wins over the decrement.
- `*_on` falls in the cycle after the counter transitions from 1 to 0.
- Inputs are registered-clean and synchronous to `clk`; no synchronisers inside the block.

## Configuration
- `REWARD_BLINK_EN` defined:
  - In SHOWN, once the shown counter ≥ `BLINK_AFTER`, `reward_show` toggles on every `tick`.
  - Before that, `reward_show` = 1.
  - Outside SHOWN, `reward_show` = 0 and the toggle flop resets to 1.
- `REWARD_BLINK_EN` undefined:
  - `reward_show` = `reward_valid`.
  - The shown counter and toggle logic are not built.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHOWN with `speed_on`=1 → all outputs 0 and FSM in IDLE asynchronously.
- **Spawn and pickup:**
  - Stimulus: `set_require`=1, type 3, pos (9,4); move tank to (9,4).
  - Response: `reward_valid`=1 one clk after the request; `set_finish`=1 and `shield_on`=1 one clk after the match.
  - Then drop `set_require` → `set_finish`=0 next clk; `shield_on` falls after exactly 40 ticks.
- **Expiry:** type 2 spawned, tank never matches, `set_require` drops → `reward_valid`=0, `set_finish` never asserted, `speed_on` stays 0.
- **Simultaneous events:** match and `set_require` fall in the same cycle → no effect applied, return to IDLE. `tick` coinciding with a second type-4 pickup at count 5 → counter reloads to 40.
- **Life and gating:** type 1 pickup → exactly one `life_add` pulse. `set_require`=1 with `reward_type`=0 → stays in IDLE until the type becomes nonzero.
- **Blink (with `REWARD_BLINK_EN`, `BLINK_AFTER`=4):** after 4 ticks in SHOWN, `reward_show` toggles on each tick. Without the macro, `reward_show` tracks `reward_valid`.

Source files
------------

// File: rtl/reward_pickup_controller.sv
// Reward pickup controller: latches a spawned reward, detects tank pickup, runs the
// four-phase set_require/set_finish handshake and times the power-up effects.
// Optional marker blinking is built when REWARD_BLINK_EN is defined.
module reward_pickup_controller #(
  parameter logic [7:0] EFFECT_TICKS = 8'd40
`ifdef REWARD_BLINK_EN
  , parameter logic [7:0] BLINK_AFTER = 8'd32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set_require,
  input  logic [2:0] reward_type,
  input  logic [4:0] random_xpos,
  input  logic [4:0] random_ypos,
  input  logic [4:0] tank_xpos,
  input  logic [4:0] tank_ypos,
  output logic       set_finish,
  output logic       reward_valid,
  output logic       reward_show,
  output logic [4:0] reward_xpos,
  output logic [4:0] reward_ypos,
  output logic [2:0] reward_kind,
  output logic       life_add,
  output logic       speed_on,
  output logic       shield_on,
  output logic       freeze_on
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOWN = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic       latch_s, expire_s, collect_s;
  logic [7:0] speed_cnt_r, shield_cnt_r, freeze_cnt_r;
  logic [7:0] speed_cnt_s, shield_cnt_s, freeze_cnt_s;

  // A pickup load beats a same-cycle tick; otherwise tick decrements down to zero.
  function automatic logic [7:0] effect_next(input logic [7:0] cnt, input logic load,
                                             input logic dec);
    if (load) begin
      return EFFECT_TICKS;
    end else if (dec && (cnt != 8'd0)) begin
      return cnt - 8'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Next-state and handshake event decode.
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    expire_s  = 1'b0;
    collect_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (set_require && (reward_type != 3'd0)) begin
          latch_s = 1'b1;
          state_s = ST_SHOWN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHOWN: begin
        if (!set_require) begin
          expire_s = 1'b1;
          state_s  = ST_IDLE;
        end else if ((tank_xpos == reward_xpos) && (tank_ypos == reward_ypos)) begin
          collect_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          state_s = ST_SHOWN;
        end
      end
      ST_ACK: begin
        if (!set_require) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Effect counter next values; they run regardless of FSM state.
  always_comb begin
    speed_cnt_s  = effect_next(speed_cnt_r,  collect_s && (reward_kind == 3'd2), tick);
    shield_cnt_s = effect_next(shield_cnt_r, collect_s && (reward_kind == 3'd3), tick);
    freeze_cnt_s = effect_next(freeze_cnt_r, collect_s && (reward_kind == 3'd4), tick);
  end

  // State, latched reward, handshake and effect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      reward_xpos  <= 5'd0;
      reward_ypos  <= 5'd0;
      reward_kind  <= 3'd0;
      set_finish   <= 1'b0;
      reward_valid <= 1'b0;
      life_add     <= 1'b0;
      speed_cnt_r  <= 8'd0;
      shield_cnt_r <= 8'd0;
      freeze_cnt_r <= 8'd0;
      speed_on     <= 1'b0;
      shield_on    <= 1'b0;
      freeze_on    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        reward_xpos <= random_xpos;
        reward_ypos <= random_ypos;
        reward_kind <= reward_type;
      end else if (expire_s) begin
        reward_kind <= 3'd0;
      end
      set_finish   <= (state_s == ST_ACK);
      reward_valid <= (state_s == ST_SHOWN);
      life_add     <= collect_s && (reward_kind == 3'd1);
      speed_cnt_r  <= speed_cnt_s;
      shield_cnt_r <= shield_cnt_s;
      freeze_cnt_r <= freeze_cnt_s;
      speed_on     <= (speed_cnt_s != 8'd0);
      shield_on    <= (shield_cnt_s != 8'd0);
      freeze_on    <= (freeze_cnt_s != 8'd0);
    end
  end

`ifdef REWARD_BLINK_EN
  logic [7:0] shown_cnt_r, shown_cnt_s;
  logic       blink_r, blink_s;

  // Shown-time counter and blink phase; the phase rests at 1 outside SHOWN.
  always_comb begin
    shown_cnt_s = shown_cnt_r;
    blink_s     = blink_r;
    if (latch_s) begin
      shown_cnt_s = 8'd0;
    end else if ((state_r == ST_SHOWN) && tick && (shown_cnt_r != 8'hFF)) begin
      shown_cnt_s = shown_cnt_r + 8'd1;
    end else begin
      shown_cnt_s = shown_cnt_r;
    end
    if (state_s != ST_SHOWN) begin
      blink_s = 1'b1;
    end else if ((state_r == ST_SHOWN) && tick && (shown_cnt_r >= BLINK_AFTER)) begin
      blink_s = ~blink_r;
    end else begin
      blink_s = blink_r;
    end
  end

  // Registered marker enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_cnt_r <= 8'd0;
      blink_r     <= 1'b1;
      reward_show <= 1'b0;
    end else begin
      shown_cnt_r <= shown_cnt_s;
      blink_r     <= blink_s;
      reward_show <= (state_s == ST_SHOWN) && ((shown_cnt_s < BLINK_AFTER) || blink_s);
    end
  end
`else
  assign reward_show = reward_valid;
`endif

endmodule
